// File: rtl/des_apb_pkg.sv
// rtl/des_apb_pkg.sv - shared addresses, op/state types and beat planner for des_apb_master
package des_apb_pkg;

  localparam logic [2:0] ADDR_ENC    = 3'd0;
  localparam logic [2:0] ADDR_DEC    = 3'd1;
  localparam logic [2:0] ADDR_KEY    = 3'd2;
  localparam logic [2:0] ADDR_RST    = 3'd3;
  localparam logic [2:0] ADDR_DOUT   = 3'd4;
  localparam logic [2:0] ADDR_INCNT  = 3'd5;
  localparam logic [2:0] ADDR_OUTCNT = 3'd6;

  typedef enum logic [2:0] {
    OP_ENC    = 3'd0,
    OP_DEC    = 3'd1,
    OP_KEY    = 3'd2,
    OP_RST    = 3'd3,
    OP_READ   = 3'd4,
    OP_STATUS = 3'd5
  } op_e;

  typedef enum logic [1:0] {X_IDLE, X_SETUP, X_ACCESS, X_GAP} xfer_state_e;

  typedef enum logic [2:0] {S_IDLE, S_XFER, S_NEXT, S_LAST, S_RSP} seq_state_e;

  typedef struct packed {
    logic [2:0]  addr;
    logic        write;
    logic [31:0] wdata;
  } beat_t;

  function automatic logic op_legal(logic [2:0] op);
    return op <= 3'd5;
  endfunction

  // For READ_BLOCK, beat 0 is the OUTCNT poll and beats 1..2 fetch the two output words.
  function automatic beat_t beat_plan(logic [2:0] op, logic [1:0] beat, logic [127:0] wd);
    beat_t b;
    b = '0;
    case (op)
      OP_ENC, OP_DEC: begin
        b.addr  = (op == OP_ENC) ? ADDR_ENC : ADDR_DEC;
        b.write = 1'b1;
        b.wdata = beat[0] ? wd[31:0] : wd[63:32];
      end
      OP_KEY: begin
        b.addr  = ADDR_KEY;
        b.write = 1'b1;
        case (beat)
          2'd0:    b.wdata = wd[127:96];
          2'd1:    b.wdata = wd[95:64];
          2'd2:    b.wdata = wd[63:32];
          default: b.wdata = wd[31:0];
        endcase
      end
      OP_RST: begin
        b.addr  = ADDR_RST;
        b.write = 1'b1;
      end
      OP_STATUS: b.addr = (beat == 2'd0) ? ADDR_INCNT : ADDR_OUTCNT;
      OP_READ:   b.addr = (beat == 2'd0) ? ADDR_OUTCNT : ADDR_DOUT;
      default:   b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/des_apb_master_if.sv
// rtl/des_apb_master_if.sv - host command/response stream and APB bus bundle
interface des_apb_master_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [127:0] cmd_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [63:0]  rsp_data;
  logic         rsp_err;
  logic         rsp_tmo;
  logic [2:0]   PADDR;
  logic         PSEL;
  logic         PENABLE;
  logic         PWRITE;
  logic [31:0]  PWDATA;
  logic [31:0]  PRDATA;
  logic         PSLVERR;
  logic         PREADY;

  modport master (
    input  cmd_valid, cmd_op, cmd_wdata, rsp_ready, PRDATA, PSLVERR, PREADY,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_tmo,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_wdata, rsp_ready, PRDATA, PSLVERR, PREADY,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_tmo,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_xfer_engine.sv
// rtl/apb_xfer_engine.sv - one APB transfer: SETUP, ACCESS with PREADY wait, then GAP_CYC idle cycles
module apb_xfer_engine
  import des_apb_pkg::*;
#(
  parameter int GAP_CYC = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start_i,
  input  logic [2:0]  addr_i,
  input  logic        write_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [2:0]  paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pslverr_i,
  input  logic        pready_i
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  xfer_state_e state_q;
  logic [GW-1:0] gap_q;
  logic          psel_q, penable_q, pwrite_q;
  logic [2:0]    paddr_q;
  logic [31:0]   pwdata_q;

  // A new transfer may launch in the last GAP cycle so beats stay exactly GAP_CYC apart.
  assign ready_o = (state_q == X_IDLE) || ((state_q == X_GAP) && (gap_q == GAP_LAST));
  assign done_o  = (state_q == X_ACCESS) && pready_i;
  assign rdata_o = prdata_i;
  assign err_o   = pslverr_i;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= X_IDLE;
      gap_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else if (ready_o && start_i) begin
      state_q   <= X_SETUP;
      psel_q    <= 1'b1;
      penable_q <= 1'b0;
      paddr_q   <= addr_i;
      pwrite_q  <= write_i;
      pwdata_q  <= write_i ? wdata_i : '0;
    end else begin
      case (state_q)
        X_SETUP: begin
          state_q   <= X_ACCESS;
          penable_q <= 1'b1;
        end
        X_ACCESS: begin
          if (pready_i) begin
            state_q   <= X_GAP;
            gap_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
          end
        end
        X_GAP: begin
          if (gap_q == GAP_LAST) state_q <= X_IDLE;
          else                   gap_q   <= gap_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign paddr_o   = paddr_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: rtl/des_apb_master.sv
// rtl/des_apb_master.sv - expands host ops into 3DES slave APB beat sequences and returns one response per op
module des_apb_master
  import des_apb_pkg::*;
#(
  parameter int POLL_MAX = 255,
  parameter int GAP_CYC  = 1
) (
  input logic               clk,
  input logic               n_rst,
  des_apb_master_if.master  bus
);

  localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  seq_state_e    state_q;
  logic [2:0]    op_q;
  logic [127:0]  wd_q;
  logic [1:0]    beat_q;
  logic [PW-1:0] poll_q;
  logic          cmd_ready_q, rsp_valid_q, rsp_err_q, rsp_tmo_q;
  logic [63:0]   rsp_data_q;

  logic          accept, idle, x_start, x_ready, x_done, x_err;
  logic [31:0]   x_rdata;
  beat_t         plan;

  assign idle   = (state_q == S_IDLE);
  assign accept = bus.cmd_valid && cmd_ready_q;

  // The first beat launches on the accept edge straight from the command inputs.
  assign plan    = beat_plan(idle ? bus.cmd_op : op_q,
                             idle ? 2'd0 : beat_q,
                             idle ? bus.cmd_wdata : wd_q);
  assign x_start = (accept && op_legal(bus.cmd_op)) || ((state_q == S_NEXT) && x_ready);

  apb_xfer_engine #(.GAP_CYC(GAP_CYC)) u_xfer (
    .clk       (clk),
    .n_rst     (n_rst),
    .start_i   (x_start),
    .addr_i    (plan.addr),
    .write_i   (plan.write),
    .wdata_i   (plan.wdata),
    .ready_o   (x_ready),
    .done_o    (x_done),
    .rdata_o   (x_rdata),
    .err_o     (x_err),
    .paddr_o   (bus.PADDR),
    .psel_o    (bus.PSEL),
    .penable_o (bus.PENABLE),
    .pwrite_o  (bus.PWRITE),
    .pwdata_o  (bus.PWDATA),
    .prdata_i  (bus.PRDATA),
    .pslverr_i (bus.PSLVERR),
    .pready_i  (bus.PREADY)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      wd_q        <= '0;
      beat_q      <= '0;
      poll_q      <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= !accept;
          if (accept) begin
            op_q       <= bus.cmd_op;
            wd_q       <= bus.cmd_wdata;
            beat_q     <= '0;
            poll_q     <= '0;
            rsp_data_q <= '0;
            rsp_tmo_q  <= 1'b0;
            if (op_legal(bus.cmd_op)) begin
              rsp_err_q <= 1'b0;
              state_q   <= S_XFER;
            end else begin
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RSP;
            end
          end
        end
        S_XFER: begin
          if (x_done) begin
            state_q <= S_NEXT;
            beat_q  <= beat_q + 2'd1;
            if (x_err) begin
              rsp_err_q <= 1'b1;
              state_q   <= S_LAST;
            end else begin
              case (op_q)
                OP_ENC, OP_DEC: if (beat_q == 2'd1) state_q <= S_LAST;
                OP_KEY:         if (beat_q == 2'd3) state_q <= S_LAST;
                OP_RST:         state_q <= S_LAST;
                OP_STATUS: begin
                  if (beat_q == 2'd0) rsp_data_q[35:32] <= x_rdata[3:0];
                  else begin
                    rsp_data_q[3:0] <= x_rdata[3:0];
                    state_q         <= S_LAST;
                  end
                end
                OP_READ: begin
                  if (beat_q == 2'd0) begin
                    if (x_rdata[3:0] < 4'd2) begin
                      beat_q <= '0;
                      poll_q <= poll_q + 1'b1;
                      if (poll_q == POLL_LAST) begin
                        rsp_tmo_q <= 1'b1;
                        state_q   <= S_LAST;
                      end
                    end
                  end else if (beat_q == 2'd1) begin
                    rsp_data_q[63:32] <= x_rdata;
                  end else begin
                    rsp_data_q[31:0] <= x_rdata;
                    state_q          <= S_LAST;
                  end
                end
                default: state_q <= S_LAST;
              endcase
            end
          end
        end
        S_NEXT: if (x_ready) state_q <= S_XFER;
        S_LAST: begin
          if (x_ready) begin
            rsp_valid_q <= 1'b1;
            state_q     <= S_RSP;
          end
        end
        S_RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            rsp_data_q  <= '0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_tmo   = rsp_tmo_q;

endmodule
